// File: rtl/rr_sel_pkg.sv
// Shared types and helpers for the channel select mux.
package rr_sel_pkg;

  // How the mux picks its source channel.
  typedef enum logic {
    SEL_EXPLICIT = 1'b0,
    SEL_RR       = 1'b1
  } sel_mode_e;

  // (idx + 1) mod n with an explicit wrap; never relies on counter overflow.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    int unsigned nxt;
    nxt = idx + 32'd1;
    if (nxt >= n) begin
      return 32'd0;
    end else begin
      return nxt;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority picker: the first requester at or after ptr (mod NCH) wins.
// Purely combinational.
module rr_pick #(
  parameter  int NCH = 4,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  ptr,
  output logic           gnt_valid,
  output logic [CW-1:0]  gnt_idx
);

  localparam logic [CW:0] nch_w = (CW+1)'(NCH);

  logic [CW:0] sum_s;
  logic [CW:0] idx_s;
  logic        hit_s;

  // Scan NCH positions from ptr upward, wrapping in CW+1 bits; keep the first hit.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = {CW{1'b0}};
    sum_s     = {(CW+1){1'b0}};
    idx_s     = {(CW+1){1'b0}};
    hit_s     = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      sum_s = {1'b0, ptr} + (CW+1)'(k);
      idx_s = (sum_s >= nch_w) ? (sum_s - nch_w) : sum_s;
      hit_s = ~gnt_valid & req[idx_s[CW-1:0]];
      if (hit_s) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx_s[CW-1:0];
      end else begin
        gnt_valid = gnt_valid;
        gnt_idx   = gnt_idx;
      end
    end
  end

endmodule

// File: rtl/rr_sel_mux.sv
// NCH-way channel select mux with a one-entry registered output stage.
// Source chosen by explicit index (MODE 0) or round-robin over valid channels (MODE 1).
module rr_sel_mux
  import rr_sel_pkg::*;
#(
  parameter  int NCH  = 4,
  parameter  int W    = 4,
  parameter  int MODE = 0,
  localparam int CW   = $clog2(NCH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CW-1:0]         sel,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH-1:0][W-1:0] in_data,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);

  localparam sel_mode_e   mode_c = sel_mode_e'(MODE[0]);
  localparam logic [CW:0] nch_w  = (CW+1)'(NCH);

  logic           can_take_s;
  logic           gnt_valid_s;
  logic [CW-1:0]  gnt_idx_s;
  logic [NCH-1:0] in_ready_s;
  logic           xfer_s;
  logic [W-1:0]   sel_data_s;

  logic           out_valid_r;
  logic [W-1:0]   out_data_r;
  logic [CW-1:0]  out_ch_r;
  logic [CW-1:0]  rr_ptr_r;

  assign can_take_s = ~out_valid_r | out_ready;

  generate
    if (mode_c == SEL_RR) begin : g_rr
      logic unused_sel_s;
      assign unused_sel_s = ^sel;

      rr_pick #(.NCH(NCH)) u_pick (
        .req       (in_valid),
        .ptr       (rr_ptr_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
      );
    end else begin : g_sel
      logic unused_ptr_s;
      assign unused_ptr_s = ^rr_ptr_r;

      // Explicit select; an index past the last channel grants nothing.
      always_comb begin
        gnt_idx_s = sel;
        if ({1'b0, sel} < nch_w) begin
          gnt_valid_s = 1'b1;
        end else begin
          gnt_valid_s = 1'b0;
        end
      end
    end
  endgenerate

  // One-hot ready for the granted channel and the matching data word; all defaults first.
  always_comb begin
    in_ready_s = {NCH{1'b0}};
    sel_data_s = {W{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx_s == CW'(i)) begin
        in_ready_s[i] = gnt_valid_s & can_take_s & ~rst;
        sel_data_s    = in_data[i];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
  end

  assign xfer_s = |(in_ready_s & in_valid);

  // Output register and round-robin pointer: load on transfer, clear valid on a bare drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {W{1'b0}};
      out_ch_r    <= {CW{1'b0}};
      rr_ptr_r    <= {CW{1'b0}};
    end else begin
      if (xfer_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= sel_data_s;
        out_ch_r    <= gnt_idx_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
      if (xfer_s && (mode_c == SEL_RR)) begin
        rr_ptr_r <= CW'(next_idx(32'(gnt_idx_s), 32'(NCH)));
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_rr_sel_mux.sv
// Scoreboard bench for rr_sel_mux: four configurations share one stimulus stream.
// d0: MODE0 NCH=4, d1: MODE0 NCH=3, d2: MODE1 NCH=3, d3: MODE1 NCH=4 (all W=4).
module tb_rr_sel_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel_t;
  logic [3:0]  in_valid_t;
  logic [15:0] in_data_t;
  logic        out_ready_t;

  logic [3:0] rdy0, rdy3;
  logic [2:0] rdy1, rdy2;
  logic       ov_a [4];
  logic [3:0] od_a [4];
  logic [1:0] oc_a [4];
  logic [3:0] rdy_a [4];

  assign rdy_a[0] = rdy0;
  assign rdy_a[1] = {1'b0, rdy1};
  assign rdy_a[2] = {1'b0, rdy2};
  assign rdy_a[3] = rdy3;

  int dut_nch [4]  = '{4, 3, 3, 4};
  int dut_mode [4] = '{0, 0, 1, 1};

  // Reference model state: occupancy, rotation pointer, expected words in order.
  bit         full_m [4];
  int         ptr_m [4];
  bit         exp_ov [4];
  logic [3:0] exp_rdy [4];
  logic [5:0] sb_q [4][$];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  rr_sel_mux #(.NCH(4), .W(4), .MODE(0)) u_d0 (
    .clk(clk), .rst(rst), .sel(sel_t), .in_valid(in_valid_t), .in_data(in_data_t),
    .in_ready(rdy0), .out_valid(ov_a[0]), .out_data(od_a[0]), .out_ch(oc_a[0]),
    .out_ready(out_ready_t));
  rr_sel_mux #(.NCH(3), .W(4), .MODE(0)) u_d1 (
    .clk(clk), .rst(rst), .sel(sel_t), .in_valid(in_valid_t[2:0]), .in_data(in_data_t[11:0]),
    .in_ready(rdy1), .out_valid(ov_a[1]), .out_data(od_a[1]), .out_ch(oc_a[1]),
    .out_ready(out_ready_t));
  rr_sel_mux #(.NCH(3), .W(4), .MODE(1)) u_d2 (
    .clk(clk), .rst(rst), .sel(sel_t), .in_valid(in_valid_t[2:0]), .in_data(in_data_t[11:0]),
    .in_ready(rdy2), .out_valid(ov_a[2]), .out_data(od_a[2]), .out_ch(oc_a[2]),
    .out_ready(out_ready_t));
  rr_sel_mux #(.NCH(4), .W(4), .MODE(1)) u_d3 (
    .clk(clk), .rst(rst), .sel(sel_t), .in_valid(in_valid_t), .in_data(in_data_t),
    .in_ready(rdy3), .out_valid(ov_a[3]), .out_data(od_a[3]), .out_ch(oc_a[3]),
    .out_ready(out_ready_t));

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      full_m[d] = 1'b0;
      ptr_m[d]  = 0;
      sb_q[d].delete();
    end
  endtask

  // Apply one cycle of inputs and advance the reference model by the rules of the mux.
  task automatic drive(input logic [1:0] s, input logic [3:0] v, input logic [15:0] dat,
                       input logic ordy);
    @(posedge clk);
    #1;
    sel_t       = s;
    in_valid_t  = v;
    in_data_t   = dat;
    out_ready_t = ordy;
    for (int d = 0; d < 4; d++) begin
      bit can;
      bit gv;
      bit xfer;
      int g;
      can = !full_m[d] || ordy;
      gv  = 1'b0;
      g   = 0;
      if (dut_mode[d] == 0) begin
        g  = int'(s);
        gv = (g < dut_nch[d]);
      end else begin
        for (int k = 0; k < dut_nch[d]; k++) begin
          int i;
          i = (ptr_m[d] + k) % dut_nch[d];
          if (!gv && v[i]) begin
            gv = 1'b1;
            g  = i;
          end
        end
      end
      exp_ov[d]  = full_m[d];
      exp_rdy[d] = (gv && can) ? (4'b0001 << g) : 4'b0000;
      xfer = gv && can && v[g];
      if (xfer) begin
        sb_q[d].push_back({2'(g), dat[4*g +: 4]});
        full_m[d] = 1'b1;
        if (dut_mode[d] == 1) ptr_m[d] = (g + 1) % dut_nch[d];
      end else if (ordy) begin
        full_m[d] = 1'b0;
      end
    end
    chk_en = 1'b1;
  endtask

  // Monitor: mid-cycle compare of handshake outputs; pop and compare on each consumed word.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("d%0d out_valid", d), 16'(ov_a[d]), 16'(exp_ov[d]));
        chk($sformatf("d%0d in_ready", d), 16'(rdy_a[d]), 16'(exp_rdy[d]));
        if (ov_a[d] && out_ready_t) begin
          if (sb_q[d].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL d%0d scoreboard: word consumed, none expected at %0t", d, $time);
          end else begin
            logic [5:0] e;
            e = sb_q[d].pop_front();
            chk($sformatf("d%0d out_data", d), 16'(od_a[d]), 16'(e[3:0]));
            chk($sformatf("d%0d out_ch", d), 16'(oc_a[d]), 16'(e[5:4]));
          end
        end
      end
    end
  end

  initial begin
    rst         = 1'b1;
    sel_t       = 2'd0;
    in_valid_t  = 4'd0;
    in_data_t   = 16'd0;
    out_ready_t = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d reset out_valid", d), 16'(ov_a[d]), 16'd0);
      chk($sformatf("d%0d reset out_data", d), 16'(od_a[d]), 16'd0);
      chk($sformatf("d%0d reset out_ch", d), 16'(oc_a[d]), 16'd0);
    end
    rst = 1'b0;

    // Round-robin with all channels valid: d2 should cycle 0,1,2,0,1,2.
    for (int k = 0; k < 7; k++) begin
      drive(2'd0, 4'b0111, 16'($urandom), 1'b1);
      #1;
      if (k > 0) chk("rr3 out_ch seq", 16'(oc_a[2]), 16'((k - 1) % 3));
    end
    // d3 pointer is now 1: channels 0 and 3 valid -> grant 3, then wrap to 0.
    drive(2'd0, 4'b1001, 16'($urandom), 1'b1);
    #1;
    chk("rr4 wrap grant3", 16'(rdy_a[3]), 16'b1000);
    drive(2'd0, 4'b1001, 16'($urandom), 1'b1);
    #1;
    chk("rr4 wrap grant0", 16'(rdy_a[3]), 16'b0001);

    // Explicit select of channel 2 carrying 4'hA.
    drive(2'd0, 4'b0000, 16'h0000, 1'b1);
    drive(2'd2, 4'b0100, 16'h0A00, 1'b1);
    #1;
    chk("sel2 in_ready", 16'(rdy_a[0]), 16'b0100);
    drive(2'd2, 4'b0000, 16'h0000, 1'b1);
    #1;
    chk("sel2 out_valid", 16'(ov_a[0]), 16'd1);
    chk("sel2 out_data", 16'(od_a[0]), 16'hA);
    chk("sel2 out_ch", 16'(oc_a[0]), 16'd2);

    // Index 3 on a 3-channel mux selects nothing.
    drive(2'd3, 4'b0111, 16'hFFFF, 1'b1);
    #1;
    chk("sel oob in_ready nch3", 16'(rdy_a[1]), 16'd0);
    chk("sel3 in_ready nch4", 16'(rdy_a[0]), 16'b1000);
    drive(2'd3, 4'b0000, 16'h0000, 1'b1);
    #1;
    chk("sel oob out_valid nch3", 16'(ov_a[1]), 16'd0);

    // Backpressure: hold 4'h5 for three stalled cycles, then drain and fill together.
    drive(2'd1, 4'b0010, 16'h0050, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(2'd1, 4'b0010, 16'h0070, 1'b0);
      #1;
      chk("stall out_data", 16'(od_a[0]), 16'h5);
      chk("stall out_valid", 16'(ov_a[0]), 16'd1);
      chk("stall in_ready", 16'(rdy_a[0]), 16'd0);
    end
    drive(2'd1, 4'b0010, 16'h0070, 1'b1);
    #1;
    chk("refill in_ready", 16'(rdy_a[0]), 16'b0010);
    drive(2'd1, 4'b0000, 16'h0000, 1'b0);
    #1;
    chk("refill out_valid", 16'(ov_a[0]), 16'd1);
    chk("refill out_data", 16'(od_a[0]), 16'h7);
    chk("refill out_ch", 16'(oc_a[0]), 16'd1);

    // Asynchronous reset while d0 holds a word: everything clears at once.
    chk_en      = 1'b0;
    in_valid_t  = 4'b1111;
    out_ready_t = 1'b1;
    rst         = 1'b1;
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d async rst out_valid", d), 16'(ov_a[d]), 16'd0);
      chk($sformatf("d%0d async rst out_data", d), 16'(od_a[d]), 16'd0);
      chk($sformatf("d%0d async rst in_ready", d), 16'(rdy_a[d]), 16'd0);
    end
    model_reset();
    in_valid_t = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic against the reference model.
    repeat (400) begin
      drive(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 16'($urandom),
            ($urandom_range(0, 3) != 0));
    end
    repeat (3) drive(2'd0, 4'b0000, 16'h0000, 1'b1);

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
